seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Iterative shift-add multiplier with configurable operand width, bits retired per cycle and run-time signed/unsigned mode. It is the parametrised successor to the single-mode sequential multiplier. It keeps the same Start/Ready handshake and adds a one-cycle Done strobe, a fixed data-independent latency, and an asynchronous active-low reset. It is intended as a shared arithmetic unit behind datapath controllers that cannot afford a combinational DATA_WIDTH×DATA_WIDTH array.

## Interface
- DATA_WIDTH, 16, operand width W; must be ≥ 2.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration (radix 2^BITS_PER_CYCLE); must divide DATA_WIDTH; legal values 1, 2, 4.
- Clk  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- InputA  in  W  multiplicand; sampled only on the accepting edge.
- InputB  in  W  multiplier; sampled only on the accepting edge.
- Signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- Start  in  1  request; level-sensitive while Ready=1.
- Product  out  2W  result; held until the next completion.
- Ready  out  1  1 = idle, Product valid, Start accepted.
- Done  out  1  one-cycle pulse, asserted together with Ready's rising edge.

## Operation
- Define N = DATA_WIDTH / BITS_PER_CYCLE.
- The state machine has three states: IDLE, CALC and SIGN.
- **IDLE** (Ready=1): a rising edge with Start=1 accepts a request and moves to CALC.
  - Latch |InputA| and |InputB|. Magnitudes are taken only when Signed=1 and the operand MSB=1; otherwise the raw value is used.
  - Latch neg = Signed & (A[W-1] ^ B[W-1]).
  - Clear the 2W-bit accumulator and the iteration counter.
  - Drive Ready=0.
- **CALC**: on each edge, multiply the low BITS_PER_CYCLE bits of the multiplier register by the multiplicand magnitude and add the result, aligned, into the accumulator.
  - Shift the multiplier right by BITS_PER_CYCLE and increment the counter.
  - After exactly N edges, move to SIGN.
- **SIGN**: one edge.
  - Product <= neg ? -acc : acc, taken modulo 2^(2W).
  - Set Ready=1 and Done=1, then return to IDLE.
- Done drops on the following edge unconditionally.
- Width rules:
  - The magnitude of −2^(W−1) is 2^(W−1) and fits in W unsigned bits.
  - The accumulator is 2W bits and never overflows: the unsigned maximum is (2^W−1)², and the signed extreme (−2^(W−1))² = 2^(2W−2) is still a correct positive result.
- Negating zero yields zero; a zero product is never negative.
- Start while Ready=0 is ignored, and input changes during CALC/SIGN have no effect.
- If Start is still high in IDLE, including on the edge after completion, a new request is accepted on that edge. Back-to-back operation is therefore possible with no dead cycle beyond the completion edge.
- Product is not cleared on acceptance; it keeps the previous result until SIGN overwrites it.

## Timing
- Reset (nReset=0, asynchronous, any state) forces:
  - state to IDLE;
  - Product = 0, Ready = 1, Done = 0;
  - accumulator and counter to 0.
- A reset mid-operation aborts the operation: no Done is produced and Product reads 0.
- Deassertion of reset is taken on a clock edge; the first edge after deassertion may accept Start.
- Latency is fixed and independent of the data.
  - Accept at edge k: Ready=0 after k.
  - CALC on edges k+1 … k+N.
  - SIGN at edge k+N+1: Product valid, Ready=1 and Done=1 after that edge.
  - Ready is low for N+1 cycles. W=16, BITS_PER_CYCLE=1 gives 17 cycles; BITS_PER_CYCLE=4 gives 5 cycles.
- Product and Ready change only on clock edges or on reset assertion, with no combinational path from inputs to outputs.

## Test plan
- **Unsigned basic** (W=16, BPC=1): Signed=0, A=4, B=5, Start pulse → Ready low exactly 17 cycles; Product=20, Done high exactly one cycle.
- **Signed mixed**: Signed=1, A=0xFFFD (−3), B=7 → Product=0xFFFFFFEB (−21). Also A=0xFFFD, B=0xFFF9 → 21. Also A=0, B=0x8000 → 0.
- **Extremes**:
  - Signed=0, A=B=0xFFFF → 0xFFFE0001.
  - Signed=1, A=B=0x8000 → 0x40000000.
  - Signed=1, A=0x8000, B=0x7FFF → 0xC0008000.
- **Handshake**:
  - Start held high for three operations → three Done pulses 18 edges apart with correct Products.
  - Change A/B and pulse Start mid-CALC → result unaffected, no extra operation.
- **Reset mid-operation**: assert nReset at CALC cycle 6 between edges → Ready=1 and Product=0 immediately; no Done. The next request computes 9×9=81 correctly.
- **Radix** (BPC=4, W=16, and W=8 with BPC=2): random signed/unsigned operands against a reference model → Ready low 5 cycles for both configurations; all Products match.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per cycle,
// with run-time signed/unsigned operands and a fixed N+1 cycle latency.
module seq_multiplier #(
    parameter int DATA_WIDTH     = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic [DATA_WIDTH-1:0]     InputA,
    input  logic [DATA_WIDTH-1:0]     InputB,
    input  logic                      Signed,
    input  logic                      Start,
    output logic [2*DATA_WIDTH-1:0]   Product,
    output logic                      Ready,
    output logic                      Done
);

    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t                    state, state_next;
    logic [DATA_WIDTH-1:0]     mcand, mplier;
    logic [DATA_WIDTH-1:0]     mag_a, mag_b;
    logic [2*DATA_WIDTH-1:0]   acc, partial;
    logic [CW-1:0]             cnt;
    logic                      neg;

    // Negating -2^(W-1) wraps to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = (Signed && InputA[DATA_WIDTH-1]) ? -InputA : InputA;
        mag_b = (Signed && InputB[DATA_WIDTH-1]) ? -InputB : InputB;
        partial = ({{(2*DATA_WIDTH-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]}
                   * {{DATA_WIDTH{1'b0}}, mcand}) << (cnt * BITS_PER_CYCLE);
    end

    assign Ready = (state == IDLE);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = SIGN;
            SIGN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            Product <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= Signed & (InputA[DATA_WIDTH-1] ^ InputB[DATA_WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc + partial;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + CW'(1);
                end
                SIGN: begin
                    Product <= neg ? -acc : acc;
                    Done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: W=16/BPC=1 main instance plus two radix instances
// (W=16/BPC=4 and W=8/BPC=2) checked against an arithmetic reference.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        sgn, start_m, start_r;
    logic [31:0] prod_m, prod4;
    logic [15:0] prod8;
    logic        rdy_m, done_m, rdy4, done4, rdy8, done8;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1)) dut (
        .Clk(clk), .nReset(rst_n), .InputA(a), .InputB(b), .Signed(sgn),
        .Start(start_m), .Product(prod_m), .Ready(rdy_m), .Done(done_m));

    seq_multiplier #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
        .Clk(clk), .nReset(rst_n), .InputA(a), .InputB(b), .Signed(sgn),
        .Start(start_r), .Product(prod4), .Ready(rdy4), .Done(done4));

    seq_multiplier #(.DATA_WIDTH(8), .BITS_PER_CYCLE(2)) dut8 (
        .Clk(clk), .nReset(rst_n), .InputA(a[7:0]), .InputB(b[7:0]), .Signed(sgn),
        .Start(start_r), .Product(prod8), .Ready(rdy8), .Done(done8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product via native signed arithmetic, masked to 2w bits.
    function automatic logic [63:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input int w);
        longint xv, yv, p;
        xv = longint'(x) & ((longint'(1) << w) - 1);
        yv = longint'(y) & ((longint'(1) << w) - 1);
        if (s && xv[w-1]) xv = xv - (longint'(1) << w);
        if (s && yv[w-1]) yv = yv - (longint'(1) << w);
        p = xv * yv;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // mode 0: plain op; 1: disturb inputs/Start mid-CALC; 2: reset at CALC cycle 6
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic ts, input logic [31:0] exp, input int mode);
        int low;
        int dones;
        @(negedge clk);
        a = ta; b = tb; sgn = ts; start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        low = 0;
        dones = 0;
        while (rdy_m === 1'b0 && low < 100) begin
            if (done_m === 1'b1) dones++;
            low++;
            if (mode == 1 && low == 5) begin
                a = 16'h1234; b = 16'h5678; sgn = 1'b1; start_m = 1'b1;
            end
            if (mode == 1 && low == 6) start_m = 1'b0;
            if (mode == 2 && low == 6) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, " ready"}, 64'(rdy_m), 64'd1);
                chk({tag, " product"}, 64'(prod_m), 64'd0);
                chk({tag, " done"}, 64'(done_m), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (done_m === 1'b1) dones++;
                end
                chk({tag, " no done"}, 64'(dones), 64'd0);
                return;
            end
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, 64'(low), 64'd17);
        chk({tag, " early done"}, 64'(dones), 64'd0);
        chk({tag, " done"}, 64'(done_m), 64'd1);
        chk({tag, " product"}, 64'(prod_m), 64'(exp));
        @(negedge clk);
        chk({tag, " done drop"}, 64'(done_m), 64'd0);
        chk({tag, " stays ready"}, 64'(rdy_m), 64'd1);
    endtask

    task automatic run_radix(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                             input logic ts);
        int low4;
        int low8;
        int n;
        @(negedge clk);
        a = ta; b = tb; sgn = ts; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        low4 = 0;
        low8 = 0;
        n = 0;
        while ((rdy4 === 1'b0 || rdy8 === 1'b0) && n < 50) begin
            if (rdy4 === 1'b0) low4++;
            if (rdy8 === 1'b0) low8++;
            n++;
            @(negedge clk);
        end
        chk({tag, " busy16x4"}, 64'(low4), 64'd5);
        chk({tag, " busy8x2"}, 64'(low8), 64'd5);
        chk({tag, " done16x4"}, 64'(done4), 64'd1);
        chk({tag, " done8x2"}, 64'(done8), 64'd1);
        chk({tag, " prod16x4"}, 64'(prod4), model(ta, tb, ts, 16));
        chk({tag, " prod8x2"}, 64'(prod8), model(ta, tb, ts, 8));
    endtask

    initial begin
        int cyc;
        int nd;
        int done_at [3];
        rst_n = 1'b0; a = '0; b = '0; sgn = 1'b0; start_m = 1'b0; start_r = 1'b0;
        done_at = '{0, 0, 0};

        #12;
        chk("reset ready", 64'(rdy_m), 64'd1);
        chk("reset product", 64'(prod_m), 64'd0);
        chk("reset done", 64'(done_m), 64'd0);
        chk("reset ready16x4", 64'(rdy4), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u4x5",     16'd4,    16'd5,    1'b0, 32'd20,        0);
        run_op("s-3x7",    16'hFFFD, 16'd7,    1'b1, 32'hFFFFFFEB,  0);
        run_op("s-3x-7",   16'hFFFD, 16'hFFF9, 1'b1, 32'd21,        0);
        run_op("s0xmin",   16'h0000, 16'h8000, 1'b1, 32'd0,         0);
        run_op("umax",     16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001,  0);
        run_op("sminsq",   16'h8000, 16'h8000, 1'b1, 32'h40000000,  0);
        run_op("sminxmax", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000,  0);

        // Start held high across three operations; operands change at each Done.
        @(negedge clk);
        a = 16'd3; b = 16'd4; sgn = 1'b0; start_m = 1'b1;
        cyc = 0;
        nd = 0;
        while (nd < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done_m === 1'b1) begin
                done_at[nd] = cyc;
                if (nd == 0) begin
                    chk("b2b prod0", 64'(prod_m), 64'd12);
                    a = 16'd100; b = 16'd200; sgn = 1'b1;
                end else if (nd == 1) begin
                    chk("b2b prod1", 64'(prod_m), 64'd20000);
                    a = 16'hFFFF; b = 16'd2; sgn = 1'b1;
                end else begin
                    chk("b2b prod2", 64'(prod_m), 64'hFFFFFFFE);
                    start_m = 1'b0;
                end
                nd++;
            end
        end
        start_m = 1'b0;
        chk("b2b done count", 64'(nd), 64'd3);
        chk("b2b gap1", 64'(done_at[1] - done_at[0]), 64'd18);
        chk("b2b gap2", 64'(done_at[2] - done_at[1]), 64'd18);
        @(negedge clk);
        chk("b2b idle after", 64'(rdy_m), 64'd1);

        run_op("midcalc", 16'd6,  16'd7,  1'b0, 32'd42, 1);
        run_op("abort",   16'd10, 16'd10, 1'b0, 32'd0,  2);
        run_op("after",   16'd9,  16'd9,  1'b0, 32'd81, 0);

        run_radix("r umax",  16'hFFFF, 16'hFFFF, 1'b0);
        run_radix("r smin",  16'h8080, 16'h8080, 1'b1);
        run_radix("r mixed", 16'hFFFD, 16'h0007, 1'b1);
        for (int i = 0; i < 6; i++)
            run_radix($sformatf("r rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
